udt_encode: RTL and testbench
=============================

UDT_ENCODE -- requirements
Module: udt_encode
Interface
REQ-001 SHALL have parameter C_S_AXI_DATA_WIDTH, default 64, stream width; only 64 is supported.
REQ-002 SHALL have parameter CLK_PER_US, default 125, core_clk cycles per timestamp microsecond.
REQ-003 SHALL have core_clk  input  1  sole clock; all logic on its rising edge.
REQ-004 SHALL have core_rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 SHALL have req_valid  input  1  packet request valid.
REQ-006 SHALL have req_ready  output  1  request accepted when req_valid&&req_ready.
REQ-007 SHALL have req_type  input  3  0 data, 1 ACK, 2 ACK2, 3 keep-alive, 4 NAK, 5 handshake, 6 close, 7 invalid.
REQ-008 SHALL have req_info  input  32  message number (data) or additional info (control).
REQ-009 SHALL have req_seq  input  31  sequence number, data packets only.
REQ-010 SHALL have req_sock_id  input  32  destination socket ID.
REQ-011 SHALL have req_has_payload  input  1  payload beats follow the header.
REQ-012 SHALL have in_tdata/in_tkeep/in_tvalid/in_tlast  input  64/8/1/1  payload stream.
REQ-013 SHALL have in_tready  output  1  payload stream ready.
REQ-014 SHALL have out_tdata/out_tkeep/out_tvalid/out_tlast  output  64/8/1/1  encoded UDT packet stream, registered.
REQ-015 SHALL have out_tready  input  1  downstream ready.
REQ-016 SHALL have error  output  1  one-cycle pulse on rejected request.
REQ-017 SHALL have tx_pkt_cnt  output  32  packets fully sent, wraps 0xFFFFFFFF->0.
Function
REQ-018 SHALL implement states IDLE, HDR0, HDR1, PAYLOAD; IDLE->HDR0 on accepted valid request; HDR0->HDR1 and HDR1->PAYLOAD or IDLE on output handshake; PAYLOAD->IDLE on handshake of the in_tlast beat.
REQ-019 SHALL assert req_ready only in IDLE; on acceptance latch type, info, seq, sock_id, has_payload and current timestamp.
REQ-020 SHALL reject req_type 7, and req_type 0 with req_has_payload=0: pulse error for 1 cycle, stay IDLE, emit nothing, not count.
REQ-021 SHALL encode control HDR0 as {1, type15, 16'h0, req_info}, type15 = 0 handshake, 1 keep-alive, 2 ACK, 3 NAK, 5 close, 6 ACK2.
REQ-022 SHALL encode data HDR0 as {0, req_seq, req_info}.
REQ-023 SHALL encode HDR1 as {timestamp[31:0], req_sock_id}; header beats have out_tkeep=8'hFF.
REQ-024 SHALL set out_tlast on HDR1 when has_payload=0, else on the beat carrying in_tlast.
REQ-025 SHALL present the first header beat the cycle after acceptance; hold out_tdata/out_tkeep/out_tlast stable while out_tvalid&&!out_tready.
REQ-026 SHALL in PAYLOAD drive in_tready = !out_tvalid || out_tready, copying in_tdata/in_tkeep/in_tlast to outputs one cycle after each input handshake; no bubbles while both sides ready.
REQ-027 SHALL hold in_tready=0 outside PAYLOAD; early payload beats wait.
REQ-028 SHALL increment tx_pkt_cnt by 1 on the handshake of each out_tlast beat.
REQ-029 SHALL keep a prescaler 0..CLK_PER_US-1 and 32-bit microsecond counter incrementing on prescaler wrap, wrapping to 0.
Reset
REQ-030 SHALL on core_rst_n low, at any time including mid-packet, force state IDLE and all outputs, prescaler, timestamp and tx_pkt_cnt to 0; partial packets are abandoned.
REQ-031 SHALL assert req_ready no earlier than the first clock edge after reset deassertion.
Configuration
REQ-032 SHALL with UDT_TIMESTAMP_EN defined place the latched microsecond counter in HDR1[63:32].
REQ-033 SHALL with UDT_TIMESTAMP_EN undefined omit prescaler and counter and drive HDR1[63:32]=0.
Verification
REQ-034 Keep-alive, info=0, sock=0x11223344, no payload, ready high -> 2 beats: 0x8001000000000000, {ts,0x11223344} with tlast; cnt=1.
REQ-035 Data seq=0x5, info=0x80000001, 3 payload beats, last tkeep=0x0F -> 5 beats, HDR0=0x0000000580000001, tkeep FF,FF,FF,FF,0F, tlast on 5th only.
REQ-036 req_type=7 and data with has_payload=0 -> error pulses 1 cycle each, no out_tvalid, cnt unchanged.
REQ-037 ACK with out_tready toggling 1/0 every cycle -> out_tdata held during stalls, no beat lost or duplicated.
REQ-038 Reset asserted during payload beat 2 of 4 -> outputs 0 immediately; next handshake packet after reset is correct with cnt=1.
REQ-039 CLK_PER_US=4, UDT_TIMESTAMP_EN defined, request at cycle 40 after reset -> HDR1[63:32]=10; undefined -> 0.

Source files
------------

// File: rtl/udt_encode.sv
// UDT packet encoder: header-first framing of data/control packets onto a 64-bit stream.
// Optional header timestamp is enabled by defining UDT_TIMESTAMP_EN.
`timescale 1ns/1ps
module udt_encode #(
  parameter int unsigned C_S_AXI_DATA_WIDTH = 64,
  parameter int unsigned CLK_PER_US         = 125
) (
  input  logic                            core_clk,
  input  logic                            core_rst_n,
  input  logic                            req_valid,
  output logic                            req_ready,
  input  logic [2:0]                      req_type,
  input  logic [31:0]                     req_info,
  input  logic [30:0]                     req_seq,
  input  logic [31:0]                     req_sock_id,
  input  logic                            req_has_payload,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]   in_tdata,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0] in_tkeep,
  input  logic                            in_tvalid,
  input  logic                            in_tlast,
  output logic                            in_tready,
  output logic [C_S_AXI_DATA_WIDTH-1:0]   out_tdata,
  output logic [C_S_AXI_DATA_WIDTH/8-1:0] out_tkeep,
  output logic                            out_tvalid,
  output logic                            out_tlast,
  input  logic                            out_tready,
  output logic                            error,
  output logic [31:0]                     tx_pkt_cnt
);

  typedef enum logic [1:0] {StIdle, StHdr0, StHdr1, StPayload} state_e;

  state_e                            state_q, state_d;
  logic [31:0]                       sock_q, sock_d;
  logic                              has_pl_q, has_pl_d;
  logic [31:0]                       ts_lat_q, ts_lat_d;
  logic                              rdy_en_q;
  logic [C_S_AXI_DATA_WIDTH-1:0]     tdata_q, tdata_d;
  logic [C_S_AXI_DATA_WIDTH/8-1:0]   tkeep_q, tkeep_d;
  logic                              tvalid_q, tvalid_d;
  logic                              tlast_q, tlast_d;
  logic                              error_q, error_d;
  logic [31:0]                       cnt_q, cnt_d;
  logic [31:0]                       ts_now;
  logic [14:0]                       type15;
  logic [63:0]                       hdr0;
  logic                              out_hs, bad_req;

`ifdef UDT_TIMESTAMP_EN
  logic [31:0] presc_q, presc_d, ts_q, ts_d;

  always_comb begin
    presc_d = presc_q + 32'd1;
    ts_d    = ts_q;
    if (presc_q == CLK_PER_US - 1) begin
      presc_d = '0;
      ts_d    = ts_q + 32'd1;
    end
  end

  always_ff @(posedge core_clk or negedge core_rst_n) begin
    if (!core_rst_n) begin
      presc_q <= '0;
      ts_q    <= '0;
    end else begin
      presc_q <= presc_d;
      ts_q    <= ts_d;
    end
  end

  assign ts_now = ts_q;
`else
  logic unused_clk_per_us;
  assign unused_clk_per_us = ^CLK_PER_US;
  assign ts_now = '0;
`endif

  // Request type to UDT control type field.
  always_comb begin
    type15 = 15'd0;
    case (req_type)
      3'd1:    type15 = 15'd2;
      3'd2:    type15 = 15'd6;
      3'd3:    type15 = 15'd1;
      3'd4:    type15 = 15'd3;
      3'd6:    type15 = 15'd5;
      default: type15 = 15'd0;
    endcase
  end

  assign hdr0    = (req_type == 3'd0) ? {1'b0, req_seq, req_info}
                                      : {1'b1, type15, 16'h0, req_info};
  assign bad_req = (req_type == 3'd7) || ((req_type == 3'd0) && !req_has_payload);
  assign out_hs  = tvalid_q && out_tready;

  // Only accept when the output register is free so a trailing payload beat is never clobbered.
  assign req_ready = (state_q == StIdle) && rdy_en_q && (!tvalid_q || out_tready);
  assign in_tready = (state_q == StPayload) && (!tvalid_q || out_tready);

  always_comb begin
    state_d  = state_q;
    sock_d   = sock_q;
    has_pl_d = has_pl_q;
    ts_lat_d = ts_lat_q;
    tdata_d  = tdata_q;
    tkeep_d  = tkeep_q;
    tvalid_d = tvalid_q;
    tlast_d  = tlast_q;
    error_d  = 1'b0;
    cnt_d    = cnt_q;

    if (out_hs) begin
      tvalid_d = 1'b0;
      if (tlast_q) cnt_d = cnt_q + 32'd1;
    end

    unique case (state_q)
      StIdle: begin
        if (req_valid && req_ready) begin
          if (bad_req) begin
            error_d = 1'b1;
          end else begin
            state_d  = StHdr0;
            sock_d   = req_sock_id;
            has_pl_d = req_has_payload;
            ts_lat_d = ts_now;
            tdata_d  = hdr0;
            tkeep_d  = '1;
            tvalid_d = 1'b1;
            tlast_d  = 1'b0;
          end
        end
      end
      StHdr0: begin
        if (out_hs) begin
          state_d  = StHdr1;
          tdata_d  = {ts_lat_q, sock_q};
          tkeep_d  = '1;
          tvalid_d = 1'b1;
          tlast_d  = !has_pl_q;
        end
      end
      StHdr1: begin
        if (out_hs) state_d = has_pl_q ? StPayload : StIdle;
      end
      StPayload: begin
        if (in_tvalid && in_tready) begin
          tdata_d  = in_tdata;
          tkeep_d  = in_tkeep;
          tvalid_d = 1'b1;
          tlast_d  = in_tlast;
          if (in_tlast) state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge core_clk or negedge core_rst_n) begin
    if (!core_rst_n) begin
      state_q  <= StIdle;
      sock_q   <= '0;
      has_pl_q <= 1'b0;
      ts_lat_q <= '0;
      rdy_en_q <= 1'b0;
      tdata_q  <= '0;
      tkeep_q  <= '0;
      tvalid_q <= 1'b0;
      tlast_q  <= 1'b0;
      error_q  <= 1'b0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      sock_q   <= sock_d;
      has_pl_q <= has_pl_d;
      ts_lat_q <= ts_lat_d;
      rdy_en_q <= 1'b1;
      tdata_q  <= tdata_d;
      tkeep_q  <= tkeep_d;
      tvalid_q <= tvalid_d;
      tlast_q  <= tlast_d;
      error_q  <= error_d;
      cnt_q    <= cnt_d;
    end
  end

  assign out_tdata  = tdata_q;
  assign out_tkeep  = tkeep_q;
  assign out_tvalid = tvalid_q;
  assign out_tlast  = tlast_q;
  assign error      = error_q;
  assign tx_pkt_cnt = cnt_q;

endmodule

// File: tb/tb_udt_encode.sv
// Self-checking bench for udt_encode: directed and randomized packets against a packet-level model.
`timescale 1ns/1ps
module tb_udt_encode;
  localparam int unsigned P = 4;

  logic        core_clk = 1'b0;
  logic        core_rst_n = 1'b0;
  logic        req_valid = 1'b0, req_ready;
  logic [2:0]  req_type = '0;
  logic [31:0] req_info = '0;
  logic [30:0] req_seq = '0;
  logic [31:0] req_sock_id = '0;
  logic        req_has_payload = 1'b0;
  logic [63:0] in_tdata = '0;
  logic [7:0]  in_tkeep = '0;
  logic        in_tvalid = 1'b0, in_tlast = 1'b0, in_tready;
  logic [63:0] out_tdata;
  logic [7:0]  out_tkeep;
  logic        out_tvalid, out_tlast;
  logic        out_tready = 1'b1;
  logic        error;
  logic [31:0] tx_pkt_cnt;

  always #5 core_clk = ~core_clk;

  udt_encode #(.C_S_AXI_DATA_WIDTH(64), .CLK_PER_US(P)) dut (
    .core_clk(core_clk), .core_rst_n(core_rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_type(req_type), .req_info(req_info),
    .req_seq(req_seq), .req_sock_id(req_sock_id), .req_has_payload(req_has_payload),
    .in_tdata(in_tdata), .in_tkeep(in_tkeep), .in_tvalid(in_tvalid), .in_tlast(in_tlast),
    .in_tready(in_tready), .out_tdata(out_tdata), .out_tkeep(out_tkeep),
    .out_tvalid(out_tvalid), .out_tlast(out_tlast), .out_tready(out_tready),
    .error(error), .tx_pkt_cnt(tx_pkt_cnt)
  );

  int          tests = 0;
  int          fails = 0;
  int unsigned cyc;
  int unsigned cnt_exp = 0;
  logic [72:0] mon_q[$];
  logic        stall_seen;
  logic [72:0] stall_beat;
  logic [14:0] t15 [8] = '{15'd0, 15'd2, 15'd6, 15'd1, 15'd3, 15'd0, 15'd5, 15'd0};

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Edges since reset release; a request accepted at edge k latches timestamp (k-1)/P.
  always @(posedge core_clk or negedge core_rst_n)
    if (!core_rst_n) cyc <= 0;
    else cyc <= cyc + 1;

  always @(negedge core_clk) begin
    if (!core_rst_n) begin
      stall_seen <= 1'b0;
    end else begin
      if (stall_seen) check("stall_hold", {out_tvalid, out_tdata, out_tkeep, out_tlast},
                            {1'b1, stall_beat});
      if (out_tvalid && out_tready) mon_q.push_back({out_tdata, out_tkeep, out_tlast});
      stall_seen <= out_tvalid && !out_tready;
      stall_beat <= {out_tdata, out_tkeep, out_tlast};
    end
  end

  task automatic run_pkt(input logic [2:0] typ, input logic [31:0] info, input logic [30:0] seq,
                         input logic [31:0] sock, input logic hp, input int nb,
                         input logic [7:0] lkeep, input int mode, input int abort_at,
                         input string tag);
    logic [63:0] pd[$];
    logic [72:0] exp_q[$];
    logic [63:0] hdr0;
    logic [31:0] ts;
    logic        req_hs, in_hs;
    int          bi, budget, nexp;
    int unsigned acc_cyc;
    bi = 0;
    acc_cyc = 0;
    nexp = 2 + (hp ? nb : 0);
    for (int i = 0; i < nb; i++) pd.push_back({$urandom, $urandom});
    mon_q.delete();
    req_valid = 1'b1; req_type = typ; req_info = info; req_seq = seq;
    req_sock_id = sock; req_has_payload = hp;
    out_tready = 1'b1;
    for (budget = 0; budget < 400; budget++) begin
      in_tvalid = hp && (bi < nb);
      in_tdata  = (bi < nb) ? pd[bi] : 64'h0;
      in_tkeep  = (bi == nb - 1) ? lkeep : 8'hFF;
      in_tlast  = (bi == nb - 1);
      @(negedge core_clk);
      req_hs = req_valid && req_ready;
      in_hs  = in_tvalid && in_tready;
      if (req_hs) acc_cyc = cyc;
      @(posedge core_clk);
      #1;
      if (req_hs) req_valid = 1'b0;
      if (in_hs) bi++;
      if (mode == 1) out_tready = !out_tready;
      else if (mode == 2) out_tready = 1'($urandom_range(0, 1));
      if (abort_at >= 0 && bi == abort_at) break;
      if (!req_valid && mon_q.size() >= nexp) break;
    end
    in_tvalid = 1'b0;
    in_tlast = 1'b0;
    if (abort_at < 0) begin
      check({tag, "_timeout"}, 32'(budget < 400), 32'd1);
`ifdef UDT_TIMESTAMP_EN
      ts = acc_cyc / P;
`else
      ts = 32'd0;
`endif
      hdr0 = (typ == 3'd0) ? {1'b0, seq, info} : {1'b1, t15[typ], 16'h0, info};
      exp_q.push_back({hdr0, 8'hFF, 1'b0});
      exp_q.push_back({ts, sock, 8'hFF, !hp});
      if (hp) for (int i = 0; i < nb; i++)
        exp_q.push_back({pd[i], (i == nb - 1) ? lkeep : 8'hFF, i == nb - 1});
      cnt_exp++;
      check({tag, "_nbeats"}, 32'(mon_q.size()), 32'(exp_q.size()));
      for (int i = 0; i < exp_q.size(); i++)
        if (i < mon_q.size()) check($sformatf("%s_beat%0d", tag, i), mon_q[i], exp_q[i]);
      check({tag, "_cnt"}, tx_pkt_cnt, cnt_exp);
    end
  endtask

  task automatic reject(input logic [2:0] typ, input logic hp, input string tag);
    req_valid = 1'b1; req_type = typ; req_has_payload = hp; out_tready = 1'b1;
    @(negedge core_clk);
    check({tag, "_ready"}, req_ready, 1'b1);
    @(posedge core_clk);
    #1 req_valid = 1'b0;
    @(negedge core_clk);
    check({tag, "_err_hi"}, {error, out_tvalid}, 2'b10);
    @(negedge core_clk);
    check({tag, "_err_lo"}, {error, out_tvalid}, 2'b00);
    check({tag, "_cnt"}, tx_pkt_cnt, cnt_exp);
    @(posedge core_clk);
    #1;
  endtask

  initial begin
    logic [2:0]  t;
    logic        hp;
    int          nb, mode;
    logic [39:0] kv;
    logic [4:0]  lv;

    #12;
    check("reset_outputs", {out_tvalid, out_tdata, out_tkeep, out_tlast, error, tx_pkt_cnt,
                            req_ready, in_tready}, 128'd0);
    @(posedge core_clk);
    #3 core_rst_n = 1'b1;
    #1 check("ready_before_edge", req_ready, 1'b0);
    @(posedge core_clk);
    #1 check("ready_after_edge", req_ready, 1'b1);

    run_pkt(3'd3, 32'h0, 31'h0, 32'h1122_3344, 1'b0, 0, 8'hFF, 0, -1, "keepalive");
    check("keepalive_hdr0", mon_q[0][72:9], 64'h8001_0000_0000_0000);
    check("keepalive_cnt1", tx_pkt_cnt, 32'd1);

    run_pkt(3'd0, 32'h8000_0001, 31'h5, $urandom, 1'b1, 3, 8'h0F, 0, -1, "data3");
    check("data3_hdr0", mon_q[0][72:9], 64'h0000_0005_8000_0001);
    kv = '0;
    lv = '0;
    for (int i = 0; i < 5; i++) begin
      kv = {kv[31:0], mon_q[i][8:1]};
      lv = {lv[3:0], mon_q[i][0]};
    end
    check("data3_keeps", kv, 40'hFF_FFFF_FF0F);
    check("data3_lasts", lv, 5'b00001);

    reject(3'd7, 1'b1, "rej_type7");
    reject(3'd0, 1'b0, "rej_nopl");

    run_pkt(3'd1, $urandom, 31'h0, $urandom, 1'b0, 0, 8'hFF, 1, -1, "ack_toggle");
    run_pkt(3'd0, $urandom, 31'($urandom), $urandom, 1'b1, 4, 8'h3F, 1, -1, "data_toggle");

    for (int n = 0; n < 16; n++) begin
      t    = 3'($urandom_range(0, 6));
      hp   = (t == 3'd0) ? 1'b1 : 1'($urandom_range(0, 1));
      nb   = hp ? int'($urandom_range(1, 4)) : 0;
      mode = int'($urandom_range(0, 2));
      run_pkt(t, $urandom, 31'($urandom), $urandom, hp, nb, 8'($urandom_range(1, 255)), mode,
              -1, $sformatf("rnd%0d", n));
    end

    run_pkt(3'd0, $urandom, 31'h77, $urandom, 1'b1, 4, 8'hFF, 0, 1, "abort");
    core_rst_n = 1'b0;
    req_valid = 1'b0;
    #1 check("midpkt_reset", {out_tvalid, out_tdata, out_tkeep, out_tlast, error, tx_pkt_cnt,
                              req_ready, in_tready}, 128'd0);
    cnt_exp = 0;
    repeat (3) @(posedge core_clk);
    #3 core_rst_n = 1'b1;
    #1 check("ready_before_edge2", req_ready, 1'b0);
    @(posedge core_clk);
    #1;
    run_pkt(3'd6, $urandom, 31'h0, 32'hCAFE_0001, 1'b0, 0, 8'hFF, 0, -1, "post_reset");
    check("post_reset_cnt1", tx_pkt_cnt, 32'd1);

    while (cyc < 40) begin
      @(posedge core_clk);
      #1;
    end
    run_pkt(3'd5, 32'h1234, 31'h0, 32'h0BAD_F00D, 1'b0, 0, 8'hFF, 0, -1, "ts40");
`ifdef UDT_TIMESTAMP_EN
    check("ts40_field", mon_q[1][72:41], 32'd10);
`else
    check("ts40_field", mon_q[1][72:41], 32'd0);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
